// File: rtl/bpsk_pkg.sv
// Shared types and helpers for the BPSK transmit sequencer.
// Holds the FSM state enum, the counter width helper and the configuration check.
package bpsk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        TAIL
    } state_e;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Legal parameter set: offset inside one carrier period, the period
    // fits in the phase index, and at least one carrier cycle per symbol.
    function automatic bit cfg_ok(input int dw, input int wl,
                                  input int sh, input int cps);
        return (sh < wl) && (wl <= (1 << dw)) && (cps >= 1);
    endfunction

endpackage

// File: rtl/bpsk_tx_sequencer_if.sv
// Byte request handshake between an upstream requester and the sequencer.
// master: drives byte_in/byte_last/byte_valid; slave: drives byte_ready.
interface bpsk_tx_sequencer_if;

    logic [7:0] byte_in;
    logic       byte_last;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_last,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_last,
        input  byte_valid,
        output byte_ready
    );

endinterface

// File: rtl/bpsk_carrier_nco.sv
// Free-running carrier counter c and carrier-cycle counter k with symbol boundary flag.
// Ports: clock, reset (sync, high), c_next_o (next value of c), boundary_o (last clock of a symbol).
module bpsk_carrier_nco
    import bpsk_pkg::*;
#(
    parameter int WAVELENGTH        = 32,
    parameter int CYCLES_PER_SYMBOL = 4,
    parameter int CW                = cnt_w(WAVELENGTH)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [CW-1:0] c_next_o,
    output logic          boundary_o
);

    localparam int KW = cnt_w(CYCLES_PER_SYMBOL);

    logic [CW-1:0] c_q, c_d;
    logic [KW-1:0] k_q, k_d;
    logic          c_wrap;
    logic          k_wrap;

    always_comb begin
        c_wrap = (c_q == CW'(WAVELENGTH - 1));
        k_wrap = (k_q == KW'(CYCLES_PER_SYMBOL - 1));
        c_d    = c_wrap ? '0 : c_q + 1'b1;
        k_d    = k_q;
        if (c_wrap) begin
            k_d = k_wrap ? '0 : k_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            c_q <= '0;
            k_q <= '0;
        end else begin
            c_q <= c_d;
            k_q <= k_d;
        end
    end

    assign c_next_o   = c_d;
    assign boundary_o = c_wrap && k_wrap;

endmodule

// File: rtl/bpsk_tx_sequencer.sv
// Frames buffered bytes as preamble/data/tail symbols and emits BPSK table phase.
// Ports: clock, reset (sync, high), bus (byte handshake, slave), phase, data_bit,
// symbol_strobe, tx_active, underrun.
module bpsk_tx_sequencer
    import bpsk_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int WAVELENGTH        = 32,
    parameter int SHIFT             = 16,
    parameter int CYCLES_PER_SYMBOL = 4,
    parameter int PREAMBLE_BITS     = 8,
    parameter int TAIL_SYMBOLS      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    bpsk_tx_sequencer_if.slave    bus,
    output logic [DATA_WIDTH-1:0] phase,
    output logic                  data_bit,
    output logic                  symbol_strobe,
    output logic                  tx_active,
    output logic                  underrun
);

    if (!cfg_ok(DATA_WIDTH, WAVELENGTH, SHIFT, CYCLES_PER_SYMBOL)) begin : g_bad_cfg
        $error("bpsk_tx_sequencer: illegal parameter set");
    end

    localparam int CW = cnt_w(WAVELENGTH);
    localparam int PW = DATA_WIDTH + 1;
    localparam int SN0 = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
    localparam int SN = (TAIL_SYMBOLS > SN0) ? TAIL_SYMBOLS : SN0;
    localparam int SW = cnt_w(SN);

    logic [CW-1:0]         c_d;
    logic                  boundary;

    bpsk_carrier_nco #(
        .WAVELENGTH        (WAVELENGTH),
        .CYCLES_PER_SYMBOL (CYCLES_PER_SYMBOL),
        .CW                (CW)
    ) u_nco (
        .clock      (clock),
        .reset      (reset),
        .c_next_o   (c_d),
        .boundary_o (boundary)
    );

    state_e                state_q, state_d;
    logic [SW-1:0]         sym_q, sym_d;
    logic [7:0]            sh_q, sh_d;
    logic                  last_q, last_d;
    logic                  bit_q, bit_d;
    logic [7:0]            buf_q;
    logic                  buf_last_q;
    logic                  buf_full_q;
    logic                  rdy_q;
    logic                  und_q, und_d;
    logic                  strb_q;
    logic [DATA_WIDTH-1:0] phase_q, phase_d;
    logic                  load;
    logic                  accept;
    logic [PW-1:0]         sum;

    assign bus.byte_ready = rdy_q && !buf_full_q;
    assign accept = bus.byte_valid && bus.byte_ready;

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        sh_d    = sh_q;
        last_d  = last_q;
        bit_d   = bit_q;
        und_d   = 1'b0;
        load    = 1'b0;
        if (boundary) begin
            unique case (state_q)
                IDLE: begin
                    bit_d = 1'b0;
                    if (buf_full_q) begin
                        state_d = PREAMBLE;
                        sym_d   = '0;
                        bit_d   = 1'b1;
                    end
                end
                PREAMBLE: begin
                    if (sym_q == SW'(PREAMBLE_BITS - 1)) begin
                        sym_d = '0;
                        if (buf_full_q) begin
                            load    = 1'b1;
                            state_d = DATA;
                            sh_d    = buf_q;
                            last_d  = buf_last_q;
                            bit_d   = buf_q[0];
                        end else begin
                            und_d   = 1'b1;
                            state_d = TAIL;
                            bit_d   = 1'b0;
                        end
                    end else begin
                        sym_d = sym_q + 1'b1;
                        // Next preamble index is even (bit 1) when this one is odd.
                        bit_d = sym_q[0];
                    end
                end
                DATA: begin
                    if (sym_q == SW'(7)) begin
                        sym_d = '0;
                        if (last_q) begin
                            state_d = TAIL;
                            bit_d   = 1'b0;
                        end else if (buf_full_q) begin
                            load   = 1'b1;
                            sh_d   = buf_q;
                            last_d = buf_last_q;
                            bit_d  = buf_q[0];
                        end else begin
                            und_d   = 1'b1;
                            state_d = TAIL;
                            bit_d   = 1'b0;
                        end
                    end else begin
                        sym_d = sym_q + 1'b1;
                        sh_d  = {1'b0, sh_q[7:1]};
                        bit_d = sh_q[1];
                    end
                end
                TAIL: begin
                    bit_d = 1'b0;
                    if (sym_q == SW'(TAIL_SYMBOLS - 1)) begin
                        sym_d = '0;
                        // Back-to-back frame: skip IDLE when a byte is waiting.
                        if (buf_full_q) begin
                            state_d = PREAMBLE;
                            bit_d   = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Phase uses next-state c and bit so all three line up after the edge.
    always_comb begin
        sum = PW'(c_d) + (bit_d ? PW'(SHIFT) : PW'(0));
        if (sum >= PW'(WAVELENGTH)) begin
            phase_d = DATA_WIDTH'(sum - PW'(WAVELENGTH));
        end else begin
            phase_d = DATA_WIDTH'(sum);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            sym_q      <= '0;
            sh_q       <= '0;
            last_q     <= 1'b0;
            bit_q      <= 1'b0;
            buf_q      <= '0;
            buf_last_q <= 1'b0;
            buf_full_q <= 1'b0;
            rdy_q      <= 1'b0;
            und_q      <= 1'b0;
            strb_q     <= 1'b0;
            phase_q    <= '0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            sh_q    <= sh_d;
            last_q  <= last_d;
            bit_q   <= bit_d;
            rdy_q   <= 1'b1;
            und_q   <= und_d;
            strb_q  <= boundary && (state_d != IDLE);
            phase_q <= phase_d;
            if (load) begin
                buf_full_q <= 1'b0;
            end else if (accept) begin
                buf_full_q <= 1'b1;
                buf_q      <= bus.byte_in;
                buf_last_q <= bus.byte_last;
            end
        end
    end

    assign phase         = phase_q;
    assign data_bit      = bit_q;
    assign symbol_strobe = strb_q;
    assign tx_active     = (state_q != IDLE);
    assign underrun      = und_q;

endmodule
